axi_lite_subordinate: RTL

AXI-lite responder terminating the bus driven by the team's AXI-lite manager VIP, backed by a small register bank. It accepts single-beat writes and reads, returns B/R responses, and exposes all registers as a flat output for the FIFO control logic. It is the synthesizable target used by the FIFO end-project bench and by the CSR block.

---
 rtl/axi_lite_pkg.sv | 30 +++
 rtl/axi_lite_subordinate_if.sv | 46 ++++
 rtl/axi_lite_regbank.sv | 46 ++++
 rtl/axi_lite_subordinate.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// ----------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI-lite subordinate: response codes and the
// write/read handshake FSM state encodings.
// ----------------------------------------------------------------------------
package axi_lite_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_HAVE_ADDR = 2'd1,
    W_HAVE_DATA = 2'd2,
    W_RESP      = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  // Response code for a decoded access.
  function automatic logic [1:0] resp_for(input logic hit);
    return hit ? OKAY : DECERR;
  endfunction

endpackage

// File: rtl/axi_lite_subordinate_if.sv
// ----------------------------------------------------------------------------
// axi_lite_subordinate_if
// AXI-lite bus bundle (AW, W, B, AR, R channels). Clock and reset are not
// part of the bundle.
//   master : drives addresses, write data, valids and response readies
//   slave  : drives address/data readies and B/R responses
// ----------------------------------------------------------------------------
interface axi_lite_subordinate_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) ();

  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic                  s_axi_wlast;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;
  logic                  s_axi_rlast;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_wlast,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid, s_axi_rlast
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_wlast,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid, s_axi_rlast
  );

endinterface

// File: rtl/axi_lite_regbank.sv
// ----------------------------------------------------------------------------
// axi_lite_regbank
// NUM_REGS x DATA_WIDTH register bank, one synchronous write port, one
// combinational read port, all registers exposed as a flat vector.
//   clk_i, rst_ni : clock, async active-low reset (clears all registers)
//   we_i, waddr_i, wdata_i : write port (waddr_i must already be decoded)
//   raddr_i, rdata_o       : combinational read, 0 for unmapped index
//   reg_flat_o             : register i at [i*DATA_WIDTH +: DATA_WIDTH]
// ----------------------------------------------------------------------------
module axi_lite_regbank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           we_i,
  input  logic [ADDR_WIDTH-1:0]          waddr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [ADDR_WIDTH-1:0]          raddr_i,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat_o
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (we_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (waddr_i == ADDR_WIDTH'(i)) mem_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr_i == ADDR_WIDTH'(i)) rdata_o = mem_q[i];
    end
  end

  assign reg_flat_o = mem_q;

endmodule

// File: rtl/axi_lite_subordinate.sv
// ----------------------------------------------------------------------------
// axi_lite_subordinate
// Single-beat AXI-lite responder in front of a small register bank.
// Independent write and read FSMs, one outstanding transaction on each.
// All readies/valids/responses are registered; no ready depends
// combinationally on a valid.
//
// Ports:
//   s_axi_clk     : clock (rising edge)
//   s_axi_resetn  : async active-low reset
//   s_axi         : AXI-lite bus (slave modport)
//   reg_flat      : register i at [i*DATA_WIDTH +: DATA_WIDTH]
//
// Build option:
//   AXI_LITE_SUB_DECERR_EN defined : addresses >= NUM_REGS get DECERR, writes
//                                    dropped, reads return 0.
//   undefined                      : address wraps modulo NUM_REGS (power of
//                                    two), always OKAY.
// ----------------------------------------------------------------------------
module axi_lite_subordinate
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                           s_axi_clk,
  input  logic                           s_axi_resetn,
  axi_lite_subordinate_if.slave          s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat
);

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
  wr_state_e             w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic                  aw_hs, w_hs, commit;
  logic                  w_hit;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign aw_hs = s_axi.s_axi_awvalid & awready_q;
  assign w_hs  = s_axi.s_axi_wvalid  & wready_q;

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) waddr_d = s_axi.s_axi_awaddr;
        if (w_hs)  wdata_d = s_axi.s_axi_wdata;
        if (aw_hs && w_hs) w_state_d = W_RESP;
        else if (aw_hs)    w_state_d = W_HAVE_ADDR;
        else if (w_hs)     w_state_d = W_HAVE_DATA;
      end
      W_HAVE_ADDR: begin
        if (w_hs) begin
          wdata_d   = s_axi.s_axi_wdata;
          w_state_d = W_RESP;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs) begin
          waddr_d   = s_axi.s_axi_awaddr;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        // bvalid is always high in this state
        if (s_axi.s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Commit on the edge that enters W_RESP so reg_flat and bvalid change
  // together; the bank sees the freshly completed address/data.
  assign commit = (w_state_q != W_RESP) && (w_state_d == W_RESP);

`ifdef AXI_LITE_SUB_DECERR_EN
  assign w_hit = ((ADDR_WIDTH+1)'(waddr_d) < (ADDR_WIDTH+1)'(NUM_REGS));
  assign w_idx = waddr_d;
`else
  assign w_hit = 1'b1;
  assign w_idx = waddr_d & ADDR_WIDTH'(NUM_REGS - 1);
`endif

  always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wdata_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      awready_q <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
      wready_q  <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
      bvalid_q  <= (w_state_d == W_RESP);
      if (commit) bresp_q <= resp_for(w_hit);
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  rd_state_e             r_state_q, r_state_d;
  logic                  arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q, bank_rdata;
  logic [1:0]            rresp_q;
  logic                  ar_hs, r_hit;
  logic [ADDR_WIDTH-1:0] r_idx;

  assign ar_hs = s_axi.s_axi_arvalid & arready_q;

`ifdef AXI_LITE_SUB_DECERR_EN
  assign r_hit = ((ADDR_WIDTH+1)'(s_axi.s_axi_araddr) < (ADDR_WIDTH+1)'(NUM_REGS));
  assign r_idx = s_axi.s_axi_araddr;
`else
  assign r_hit = 1'b1;
  assign r_idx = s_axi.s_axi_araddr & ADDR_WIDTH'(NUM_REGS - 1);
`endif

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_RESP;
      R_RESP:  if (s_axi.s_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Capture reads the bank's current contents, so a write committing on
  // the same edge is not visible: the read returns the pre-write value.
  always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
    if (!s_axi_resetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == R_IDLE);
      rvalid_q  <= (r_state_d == R_RESP);
      if (ar_hs) begin
        rdata_q <= r_hit ? bank_rdata : '0;
        rresp_q <= resp_for(r_hit);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register bank
  // --------------------------------------------------------------------------
  axi_lite_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regbank (
    .clk_i      (s_axi_clk),
    .rst_ni     (s_axi_resetn),
    .we_i       (commit & w_hit),
    .waddr_i    (w_idx),
    .wdata_i    (wdata_d),
    .raddr_i    (r_idx),
    .rdata_o    (bank_rdata),
    .reg_flat_o (reg_flat)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_axi.s_axi_awready = awready_q;
  assign s_axi.s_axi_wready  = wready_q;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bresp   = bresp_q;
  assign s_axi.s_axi_arready = arready_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rlast   = rvalid_q;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;

  // Every beat is a whole transfer; wlast carries no information here.
  logic unused_wlast;
  assign unused_wlast = s_axi.s_axi_wlast;

endmodule
